// File: rtl/tile_priority_mixer.sv
// rtl/tile_priority_mixer.sv - two-stage tile/sprite priority mixer with a vblank-latched priority register
module tile_priority_mixer (
  input  logic        clk_24M,
  input  logic        RES,
  input  logic        PIX_CE,
  input  logic [11:0] DSA,
  input  logic        NSAC,
  input  logic [11:0] DSB,
  input  logic        NSBC,
  input  logic [7:0]  DFI,
  input  logic        NFIC,
  input  logic [7:0]  OBJ,
  input  logic        NOBC,
  input  logic        OBJ_PRI,
  input  logic        NHBK,
  input  logic        NVBK,
  input  logic        NHSY,
  input  logic        NVSY,
  input  logic [7:0]  DB_IN,
  input  logic        PRI_WR,
  output logic [10:0] PAL,
  output logic        NBLANK_O,
  output logic        NHSY_O,
  output logic        NVSY_O,
  output logic [7:0]  PRI_RD
);

  // Encoding doubles as the palette bank of the winning layer.
  typedef enum logic [2:0] {
    WIN_FIX = 3'd0,
    WIN_A   = 3'd1,
    WIN_B   = 3'd2,
    WIN_OBJ = 3'd3,
    WIN_BG  = 3'd4
  } win_e;

  localparam logic [7:0] PRI_RESET = 8'h70;

  logic [7:0]  pend_q, pend_d, act_q, act_d;
  logic        nvbk_prev_q, nvbk_prev_d;
  logic [7:0]  dsa_q, dsa_d, dsb_q, dsb_d, dfi_q, dfi_d, obj_q, obj_d;
  logic        nsac_q, nsac_d, nsbc_q, nsbc_d, nfic_q, nfic_d, nobc_q, nobc_d;
  logic        obj_pri_q, obj_pri_d, nhbk_q, nhbk_d, nvbk_s1_q, nvbk_s1_d;
  // Syncs are carried active-high so an all-zero pipeline reads as inactive sync.
  logic        hsy_s1_q, hsy_s1_d, vsy_s1_q, vsy_s1_d;
  logic        hsy_s2_q, hsy_s2_d, vsy_s2_q, vsy_s2_d;
  logic [10:0] pal_q, pal_d;
  logic        nblank_q, nblank_d;

  logic        vbk_fall;
  logic        cand_a, cand_b, cand_obj, blank_s1;
  win_e        win;
  logic [7:0]  colour;
  logic        unused_hi;

  assign unused_hi = ^{DSA[11:8], DSB[11:8]};

  always_comb begin
    vbk_fall    = nvbk_prev_q & ~NVBK;
    nvbk_prev_d = NVBK;
    pend_d      = PRI_WR ? DB_IN : pend_q;
    act_d       = act_q;
    if (vbk_fall) act_d = PRI_WR ? DB_IN : pend_q;
  end

  always_comb begin
    dsa_d     = dsa_q;     nsac_d    = nsac_q;
    dsb_d     = dsb_q;     nsbc_d    = nsbc_q;
    dfi_d     = dfi_q;     nfic_d    = nfic_q;
    obj_d     = obj_q;     nobc_d    = nobc_q;
    obj_pri_d = obj_pri_q; nhbk_d    = nhbk_q;
    nvbk_s1_d = nvbk_s1_q; hsy_s1_d  = hsy_s1_q;
    vsy_s1_d  = vsy_s1_q;
    if (PIX_CE) begin
      dsa_d     = DSA[7:0]; nsac_d    = NSAC;
      dsb_d     = DSB[7:0]; nsbc_d    = NSBC;
      dfi_d     = DFI;      nfic_d    = NFIC;
      obj_d     = OBJ;      nobc_d    = NOBC;
      obj_pri_d = OBJ_PRI;  nhbk_d    = NHBK;
      nvbk_s1_d = NVBK;     hsy_s1_d  = ~NHSY;
      vsy_s1_d  = ~NVSY;
    end
  end

  always_comb begin
    cand_a   = nsac_q & act_q[4];
    cand_b   = nsbc_q & act_q[5];
    cand_obj = nobc_q & act_q[6];
    win      = WIN_BG;
    if (nfic_q) begin
      win = WIN_FIX;
    end else if (cand_obj && obj_pri_q) begin
      win = WIN_OBJ;
    end else begin
      case (act_q[1:0])
        2'd0: begin
          if (cand_obj)    win = WIN_OBJ;
          else if (cand_a) win = WIN_A;
          else if (cand_b) win = WIN_B;
        end
        2'd1: begin
          if (cand_a)        win = WIN_A;
          else if (cand_obj) win = WIN_OBJ;
          else if (cand_b)   win = WIN_B;
        end
        2'd2: begin
          if (cand_obj)    win = WIN_OBJ;
          else if (cand_b) win = WIN_B;
          else if (cand_a) win = WIN_A;
        end
        default: begin
          if (cand_b)        win = WIN_B;
          else if (cand_a)   win = WIN_A;
          else if (cand_obj) win = WIN_OBJ;
        end
      endcase
    end
  end

  always_comb begin
    case (win)
      WIN_FIX: colour = dfi_q;
      WIN_A:   colour = dsa_q;
      WIN_B:   colour = dsb_q;
      WIN_OBJ: colour = obj_q;
      default: colour = 8'h00;
    endcase
    blank_s1 = ~nhbk_q | ~nvbk_s1_q;
    pal_d    = pal_q;
    nblank_d = nblank_q;
    hsy_s2_d = hsy_s2_q;
    vsy_s2_d = vsy_s2_q;
    if (PIX_CE) begin
      pal_d    = blank_s1 ? 11'h000 : {win, colour};
      nblank_d = ~blank_s1;
      hsy_s2_d = hsy_s1_q;
      vsy_s2_d = vsy_s1_q;
    end
  end

  always_ff @(posedge clk_24M or posedge RES) begin
    if (RES) begin
      pend_q      <= PRI_RESET;
      act_q       <= PRI_RESET;
      nvbk_prev_q <= 1'b1;
      dsa_q       <= '0; nsac_q    <= 1'b0;
      dsb_q       <= '0; nsbc_q    <= 1'b0;
      dfi_q       <= '0; nfic_q    <= 1'b0;
      obj_q       <= '0; nobc_q    <= 1'b0;
      obj_pri_q   <= 1'b0; nhbk_q  <= 1'b0;
      nvbk_s1_q   <= 1'b0; hsy_s1_q <= 1'b0;
      vsy_s1_q    <= 1'b0;
      pal_q       <= '0; nblank_q  <= 1'b0;
      hsy_s2_q    <= 1'b0; vsy_s2_q <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      act_q       <= act_d;
      nvbk_prev_q <= nvbk_prev_d;
      dsa_q       <= dsa_d; nsac_q    <= nsac_d;
      dsb_q       <= dsb_d; nsbc_q    <= nsbc_d;
      dfi_q       <= dfi_d; nfic_q    <= nfic_d;
      obj_q       <= obj_d; nobc_q    <= nobc_d;
      obj_pri_q   <= obj_pri_d; nhbk_q <= nhbk_d;
      nvbk_s1_q   <= nvbk_s1_d; hsy_s1_q <= hsy_s1_d;
      vsy_s1_q    <= vsy_s1_d;
      pal_q       <= pal_d; nblank_q  <= nblank_d;
      hsy_s2_q    <= hsy_s2_d; vsy_s2_q <= vsy_s2_d;
    end
  end

  assign PAL      = pal_q;
  assign NBLANK_O = nblank_q;
  assign NHSY_O   = ~hsy_s2_q;
  assign NVSY_O   = ~vsy_s2_q;
  assign PRI_RD   = act_q;

endmodule

// File: doc/tile_priority_mixer.md
TILE_PRIORITY_MIXER -- requirements
Module: tile_priority_mixer

Interface
REQ-001 SHALL have the port `clk_24M`, input, 1 bit: the single system clock; all state is clocked on its rising edge.
REQ-002 SHALL have the port `RES`, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have the port `PIX_CE`, input, 1 bit: pixel strobe, high for 1 `clk_24M` cycle in every 4 (6 MHz).
REQ-004 SHALL have the ports `DSA[11:0]` and `NSAC`, inputs: layer A pixel; `DSA[7:0]` = palette(7:4) + colour(3:0); `NSAC`=1 means opaque.
REQ-005 SHALL have the ports `DSB[11:0]` and `NSBC`, inputs: layer B pixel and its opaque flag, same format as layer A.
REQ-006 SHALL have the ports `DFI[7:0]` and `NFIC`, inputs: fix layer pixel and its opaque flag.
REQ-007 SHALL have the ports `OBJ[7:0]`, `NOBC` and `OBJ_PRI`, inputs: sprite pixel, its opaque flag, and its high-priority flag.
REQ-008 SHALL have the ports `NHBK`, `NVBK`, `NHSY` and `NVSY`, inputs: blanking and sync, all active-low.
REQ-009 SHALL have the ports `DB_IN[7:0]` and `PRI_WR`, inputs: CPU data, and a write strobe that is 1 cycle wide.
REQ-010 SHALL have the port `PAL[10:0]`, output: palette RAM index = {bank[2:0], colour[7:0]}.
REQ-011 SHALL have the ports `NBLANK_O`, `NHSY_O` and `NVSY_O`, outputs: blank and sync delayed to align with `PAL`.
REQ-012 SHALL have the port `PRI_RD[7:0]`, output: the active priority register value.

Function
REQ-013 SHALL hold two 8-bit registers, PEND and ACT; `PRI_RD` = ACT.
- ACT[1:0] = order mode.
- ACT[4] = layer A enable; ACT[5] = layer B enable; ACT[6] = OBJ enable.
- ACT[2], ACT[3] and ACT[7] are stored but have no function.
REQ-014 SHALL load PEND from `DB_IN` on any `clk_24M` cycle where `PRI_WR`=1, independent of `PIX_CE`.
REQ-015 SHALL copy PEND to ACT on the cycle that detects a falling edge of `NVBK` (previous sampled 1, current 0).
- `NVBK` is sampled every `clk_24M` cycle.
REQ-016 SHALL load `DB_IN` into both PEND and ACT when `PRI_WR` and the `NVBK` falling edge occur in the same cycle.
REQ-017 SHALL advance the pixel pipeline only on `PIX_CE`=1; with `PIX_CE`=0 all pipeline registers hold.
REQ-018 SHALL register all pixel, flag, blank and sync inputs in pipeline stage 1.
REQ-019 SHALL compute the winning layer from the stage-1 values and register it in stage 2.
- Latency: `PAL` reflects inputs presented at `PIX_CE` n on the `clk_24M` cycle after `PIX_CE` n+1 (2 pixel clocks).
REQ-020 SHALL treat a layer as a candidate only if its opaque flag=1 and its enable bit=1; FIX is always enabled.
REQ-021 SHALL resolve priority, highest first, by ACT[1:0]:
- 0 = FIX > OBJ > A > B
- 1 = FIX > A > OBJ > B
- 2 = FIX > OBJ > B > A
- 3 = FIX > B > A > OBJ
REQ-022 SHALL, when `OBJ_PRI`=1 and OBJ is a candidate, place OBJ directly below FIX regardless of mode.
REQ-023 SHALL output bank and colour per winner:
- FIX: bank 0, colour `DFI`.
- A: bank 1, colour `DSA[7:0]`.
- B: bank 2, colour `DSB[7:0]`.
- OBJ: bank 3, colour `OBJ`.
- No candidate: bank 4, colour 0x00 (background), i.e. `PAL`=0x400.
REQ-024 SHALL force `PAL`=0x000 and `NBLANK_O`=0 when the stage-1 `NHBK`=0 or `NVBK`=0; otherwise `NBLANK_O`=1.
REQ-025 SHALL delay `NHSY` and `NVSY` through both stages so that `NHSY_O` and `NVSY_O` align with `PAL`.
REQ-026 SHALL, when a priority update lands mid-pipeline, apply the new ACT to whatever stage-1 data is evaluated next; there is no retroactive effect.

Reset
REQ-027 SHALL, while `RES`=1, asynchronously force:
- PEND and ACT = 0x70 (all layers enabled, mode 0);
- every pipeline register = 0;
- `PAL`=0x000, `NBLANK_O`=0, `NHSY_O`=1, `NVSY_O`=1;
- the `NVBK` edge detector's previous-sample register = 1.
REQ-028 SHALL resume normal operation on the first `PIX_CE` after `RES` falls; reset asserted mid-line discards in-flight pixels.

Verification
REQ-029 SHALL have a bench cover mode 0 with FIX transparent, OBJ=0x25 opaque, A=0x13 opaque -> `PAL`=0x325, 2 `PIX_CE` after input.
REQ-030 SHALL have a bench cover mode 1 with the same inputs -> `PAL`=0x113; then `OBJ_PRI`=1 -> `PAL`=0x325.
REQ-031 SHALL have a bench cover all layers transparent, blank inactive -> `PAL`=0x400; then `NHBK`=0 -> `PAL`=0x000 and `NBLANK_O`=0 after 2 `PIX_CE`.
REQ-032 SHALL have a bench cover `PRI_WR` of 0x01 mid-frame -> `PRI_RD` stays 0x70 until the `NVBK` falling edge, then reads 0x01 and A/B/OBJ are disabled.
REQ-033 SHALL have a bench cover `PRI_WR` of 0x52 in the same cycle as the `NVBK` falling edge -> `PRI_RD`=0x52 on the next cycle.
REQ-034 SHALL have a bench cover `RES` pulsed mid-line -> all outputs at reset values immediately, then the first valid `PAL` 2 `PIX_CE` after release.
